sum_seg_display: RTL and testbench

Downstream consumer of `bin_adder`'s 5-bit `sum`. It captures the sum on request and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed two-digit seven-segment display. It sits between the adder and the board's display pins.

---
 rtl/sum_seg_display.sv | 155 +++++++++++++++
 tb/tb_sum_seg_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_seg_display.sv
// sum_seg_display: captures a 5-bit sum and converts it to two BCD digits
// with a sequential shift-add-3 (double-dabble) engine. The digits drive a
// time-multiplexed two-digit seven-segment display.
// Optional feature: define SUM_SEG_BLANK_EN to blank a leading zero tens digit.
module sum_seg_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t        r_state, w_state_nx;
  logic [4:0]    r_shift, w_shift_nx;
  logic [7:0]    r_bcd, w_bcd_nx;
  logic [7:0]    w_bcd_adj;
  logic [2:0]    r_cnt, w_cnt_nx;
  logic [3:0]    r_tens, w_tens_nx;
  logic [3:0]    r_ones, w_ones_nx;
  logic          r_done, w_done_nx;

  logic [CW-1:0] r_scan_cnt, w_scan_cnt_nx;
  logic          r_sel, w_sel_nx;
  logic          w_wrap;
  logic [3:0]    w_digit;
  logic [6:0]    r_seg, w_seg_nx;
  logic [1:0]    r_an, w_an_nx;

  // Seven-segment encoding, bit order {g,f,e,d,c,b,a}, active-high
  function automatic logic [6:0] f_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Conversion FSM next-state: capture on load, then five adjust-and-shift steps
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_bcd_nx   = r_bcd;
    w_cnt_nx   = r_cnt;
    w_tens_nx  = r_tens;
    w_ones_nx  = r_ones;
    w_done_nx  = 1'b0;

    w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
    w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];

    case (r_state)
      IDLE: begin
        if (load) begin
          w_shift_nx = sum_in;
          w_bcd_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = CONV;
        end
      end
      CONV: begin
        w_bcd_nx   = {w_bcd_adj[6:0], r_shift[4]};
        w_shift_nx = {r_shift[3:0], 1'b0};
        w_cnt_nx   = r_cnt + 3'd1;
        // Fifth shift: publish the freshly shifted scratch directly
        if (r_cnt == 3'd4) begin
          w_tens_nx  = w_bcd_nx[7:4];
          w_ones_nx  = w_bcd_nx[3:0];
          w_done_nx  = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Conversion FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_bcd   <= w_bcd_nx;
      r_cnt   <= w_cnt_nx;
      r_tens  <= w_tens_nx;
      r_ones  <= w_ones_nx;
      r_done  <= w_done_nx;
    end
  end

  // Scan divider and segment/anode next values. Built from next-state digits
  // and select so the registered outputs change on the same edge as them.
  always_comb begin
    w_wrap        = (r_scan_cnt == CW'(SCAN_DIV - 1));
    w_scan_cnt_nx = w_wrap ? '0 : r_scan_cnt + CW'(1);
    w_sel_nx      = r_sel ^ w_wrap;
    w_digit       = w_sel_nx ? w_tens_nx : w_ones_nx;
    w_an_nx       = w_sel_nx ? 2'b01 : 2'b10;
    w_seg_nx      = f_enc(w_digit);
`ifdef SUM_SEG_BLANK_EN
    if (w_sel_nx && (w_tens_nx == 4'd0)) begin
      w_seg_nx = '0;
    end
`endif
  end

  // Free-running scan and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_sel      <= 1'b0;
      r_an       <= 2'b10;
      r_seg      <= 7'b0111111;
    end else begin
      r_scan_cnt <= w_scan_cnt_nx;
      r_sel      <= w_sel_nx;
      r_an       <= w_an_nx;
      r_seg      <= w_seg_nx;
    end
  end

  assign busy = (r_state == CONV);
  assign done = r_done;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_sum_seg_display.sv
// Scoreboard bench for sum_seg_display: stimulus pushes expected digits and
// the edge at which done must appear; a negedge monitor pops on done and
// checks busy, an and seg every cycle against a small display model.
module tb_sum_seg_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sum_in;
  logic       load;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [1:0] an;

  sum_seg_display #(.SCAN_DIV(SD)) dut (
    .clk    (clk),
    .rst    (rst),
    .sum_in (sum_in),
    .load   (load),
    .busy   (busy),
    .done   (done),
    .seg    (seg),
    .an     (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tens;
    int ones;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic rst_q = 1'b0;
  bit   end_req = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  int   m_cnt = 0;
  bit   m_sel = 1'b0;
  int   m_t = 0;
  int   m_o = 0;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= cyc + 1;
  end

  // Monitor: model update, scoreboard pop on done, per-cycle output checks
  always @(negedge clk) begin
    exp_t       e;
    bit         exp_busy;
    logic [6:0] exp_seg;
    if (rst_q) begin
      started = 1'b1;
      q.delete();
      m_cnt = 0;
      m_sel = 1'b0;
      m_t   = 0;
      m_o   = 0;
      chk("done_in_reset", int'(done), 0);
    end else if (started) begin
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_sel = ~m_sel;
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (done) begin
        chk("done_expected", q.size(), 1 + (q.size() == 0 ? 0 : q.size() - 1));
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          m_t = e.tens;
          m_o = e.ones;
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        chk("done_seen", int'(done), 1);
        e = q.pop_front();
        m_t = e.tens;
        m_o = e.ones;
      end
    end
    if (started) begin
      exp_busy = !rst_q && (q.size() > 0) && (cyc >= q[0].due - 5);
      chk("busy", int'(busy), int'(exp_busy));
      chk("an", int'(an), m_sel ? 1 : 2);
      exp_seg = m_sel ? enc(m_t) : enc(m_o);
`ifdef SUM_SEG_BLANK_EN
      if (m_sel && m_t == 0) exp_seg = 7'b0000000;
`endif
      chk("seg", int'(seg), int'(exp_seg));
    end
    if (end_req) begin
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
    end
  end

  task automatic conv(input logic [4:0] v, input int t, input int o);
    sum_in = v;
    load   = 1'b1;
    q.push_back('{t, o, cyc + 6});
    @(negedge clk);
    load   = 1'b0;
    sum_in = ~v;
    repeat (7) @(negedge clk);
  endtask

  initial begin
    int k;
    rst    = 1'b1;
    load   = 1'b0;
    sum_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Directed conversions with hand-computed digits
    conv(5'd18, 1, 8);
    conv(5'd31, 3, 1);
    repeat (6) @(negedge clk);
    conv(5'd0, 0, 0);
    repeat (6) @(negedge clk);
    conv(5'd27, 2, 7);

    // Load while busy: the second request at edge k+2 is ignored
    sum_in = 5'd8;
    load   = 1'b1;
    q.push_back('{0, 8, cyc + 6});
    @(negedge clk);
    load   = 1'b0;
    sum_in = 5'd9;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);

    // Reset three edges into a conversion of 25: no done, digits cleared
    sum_in = 5'd25;
    load   = 1'b1;
    q.push_back('{2, 5, cyc + 6});
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Reset wins over a simultaneous load
    conv(5'd14, 1, 4);
    sum_in = 5'd7;
    load   = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back: load held high is accepted every 6 edges
    sum_in = 5'd3;
    load   = 1'b1;
    k = cyc + 1;
    q.push_back('{0, 3, k + 5});
    q.push_back('{0, 3, k + 11});
    q.push_back('{0, 3, k + 17});
    repeat (18) @(negedge clk);
    load = 1'b0;
    repeat (12) @(negedge clk);

    end_req = 1'b1;
    repeat (4) @(negedge clk);
    $display("FAIL monitor_end: got 0 expected 1 at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
